// File: rtl/prefetcher_op_arbiter.sv
// prefetcher_op_arbiter
// Shares the prefetcher data queue's single per-cycle opcode port between
// slave read data, master promise pops, master read requests and prefetch
// requests. One op is granted per cycle and registered onto the queue
// request bus. The arbiter halts on any queue-reported error until software
// clears it.
module prefetcher_op_arbiter #(
    parameter int ADDR_BITS    = 64,
    parameter int DATA_BITS    = 512,
    parameter int STARVE_W     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 slv_valid,
    output logic                 slv_ready,
    input  logic [ADDR_BITS-1:0] slv_addr,
    input  logic [DATA_BITS-1:0] slv_data,
    input  logic                 prm_valid,
    output logic                 prm_ready,
    input  logic                 mst_valid,
    output logic                 mst_ready,
    input  logic [ADDR_BITS-1:0] mst_addr,
    input  logic                 pf_valid,
    output logic                 pf_ready,
    input  logic [ADDR_BITS-1:0] pf_addr,
    input  logic                 q_dataReady,
    input  logic                 q_almostFull,
    input  logic [1:0]           q_errorCode,
    output logic [2:0]           q_reqOpcode,
    output logic [ADDR_BITS-1:0] q_reqAddr,
    output logic [DATA_BITS-1:0] q_reqData,
    input  logic                 clear_err,
    output logic                 halted,
    output logic [1:0]           err_latched
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PREF = 3'd1;
    localparam logic [2:0] OP_MST  = 3'd2;
    localparam logic [2:0] OP_SLV  = 3'd3;
    localparam logic [2:0] OP_PRM  = 3'd4;

    localparam logic [STARVE_W-1:0] STARVE_THRESH = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE    = STARVE_W'(1);

    logic [0:0]           state_q, state_d;
    logic [1:0]           err_q, err_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [2:0]           opcode_q, opcode_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    logic isRun;
    logic prmElig;
    logic pfElig;
    logic starved;
    logic slvGnt, prmGnt, mstGnt, pfGnt;

    // A promise already on the request bus means dataReady still reflects the
    // old head, so a second back-to-back pop must wait one cycle.
    assign isRun   = (state_q == ST_RUN);
    assign prmElig = isRun && q_dataReady && (opcode_q != OP_PRM);
    assign pfElig  = isRun && !q_almostFull;
    assign starved = (starve_q >= STARVE_THRESH);

    // Fixed-priority grant: slv > prm > starved pf > mst > pf, nothing in reset.
    always_comb begin
        slvGnt = 1'b0;
        prmGnt = 1'b0;
        mstGnt = 1'b0;
        pfGnt  = 1'b0;
        if (!reset) begin
            if (slv_valid) begin
                slvGnt = 1'b1;
            end else if (prm_valid && prmElig) begin
                prmGnt = 1'b1;
            end else if (pf_valid && pfElig && starved) begin
                pfGnt = 1'b1;
            end else if (mst_valid && isRun) begin
                mstGnt = 1'b1;
            end else if (pf_valid && pfElig) begin
                pfGnt = 1'b1;
            end
        end
    end

    assign slv_ready = slvGnt;
    assign prm_ready = prmGnt;
    assign mst_ready = mstGnt;
    assign pf_ready  = pfGnt;

    // Prefetch starvation counter: counts eligible-but-refused cycles, saturating.
    always_comb begin
        starve_d = starve_q;
        if (pfGnt || !pf_valid) begin
            starve_d = '0;
        end else if (pfElig && (starve_q != '1)) begin
            starve_d = starve_q + STARVE_ONE;
        end
    end

    // Next request bus contents; address and data hold when not refreshed.
    always_comb begin
        opcode_d = OP_NOP;
        addr_d   = addr_q;
        data_d   = data_q;
        if (slvGnt) begin
            opcode_d = OP_SLV;
            addr_d   = slv_addr;
            data_d   = slv_data;
        end else if (prmGnt) begin
            opcode_d = OP_PRM;
        end else if (mstGnt) begin
            opcode_d = OP_MST;
            addr_d   = mst_addr;
        end else if (pfGnt) begin
            opcode_d = OP_PREF;
            addr_d   = pf_addr;
        end
    end

    // RUN/HALT control: the first error is latched, clear_err releases HALT.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (q_errorCode != 2'd0) begin
                    state_d = ST_HALT;
                    err_d   = q_errorCode;
                end
            end
            ST_HALT: begin
                if (clear_err) begin
                    state_d = ST_RUN;
                    err_d   = 2'd0;
                end
            end
            default: begin
                state_d = ST_RUN;
                err_d   = 2'd0;
            end
        endcase
    end

    // State registers with synchronous reset; a pending op is dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            err_q    <= 2'd0;
            starve_q <= '0;
            opcode_q <= OP_NOP;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            starve_q <= starve_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign q_reqOpcode = opcode_q;
    assign q_reqAddr   = addr_q;
    assign q_reqData   = data_q;
    assign halted      = (state_q == ST_HALT);
    assign err_latched = err_q;

endmodule

// File: tb/tb_prefetcher_op_arbiter.sv
// tb_prefetcher_op_arbiter
// Directed bench for the prefetcher op arbiter. Each step drives the
// requesters, checks the combinational readys mid-cycle, pushes the expected
// request-bus contents onto a scoreboard and pops/compares after the edge.
module tb_prefetcher_op_arbiter;

    localparam int ADDR_BITS = 64;
    localparam int DATA_BITS = 512;

    typedef struct packed {
        logic [2:0]           op;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 slv_valid, slv_ready;
    logic [ADDR_BITS-1:0] slv_addr;
    logic [DATA_BITS-1:0] slv_data;
    logic                 prm_valid, prm_ready;
    logic                 mst_valid, mst_ready;
    logic [ADDR_BITS-1:0] mst_addr;
    logic                 pf_valid, pf_ready;
    logic [ADDR_BITS-1:0] pf_addr;
    logic                 q_dataReady, q_almostFull;
    logic [1:0]           q_errorCode;
    logic [2:0]           q_reqOpcode;
    logic [ADDR_BITS-1:0] q_reqAddr;
    logic [DATA_BITS-1:0] q_reqData;
    logic                 clear_err, halted;
    logic [1:0]           err_latched;

    int total = 0;
    int bad   = 0;
    exp_t sbQ[$];
    logic [ADDR_BITS-1:0] modelAddr;
    logic [DATA_BITS-1:0] modelData;

    prefetcher_op_arbiter #(
        .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .STARVE_W(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .slv_valid(slv_valid), .slv_ready(slv_ready), .slv_addr(slv_addr), .slv_data(slv_data),
        .prm_valid(prm_valid), .prm_ready(prm_ready),
        .mst_valid(mst_valid), .mst_ready(mst_ready), .mst_addr(mst_addr),
        .pf_valid(pf_valid), .pf_ready(pf_ready), .pf_addr(pf_addr),
        .q_dataReady(q_dataReady), .q_almostFull(q_almostFull), .q_errorCode(q_errorCode),
        .q_reqOpcode(q_reqOpcode), .q_reqAddr(q_reqAddr), .q_reqData(q_reqData),
        .clear_err(clear_err), .halted(halted), .err_latched(err_latched)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [DATA_BITS-1:0] obs,
                            input logic [DATA_BITS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected request and compare it with the request bus.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sbQ.pop_front();
            checkVal({tag, "_op"}, DATA_BITS'(q_reqOpcode), DATA_BITS'(e.op));
            checkVal({tag, "_addr"}, DATA_BITS'(q_reqAddr), DATA_BITS'(e.addr));
            checkVal({tag, "_data"}, q_reqData, e.data);
        end
    endtask

    // One clock step: inputs are already driven; readys order is {slv,prm,mst,pf}.
    task automatic applyStimulus(input logic [3:0] expRdy, input logic [2:0] expOp,
                                 input string tag);
        exp_t e;
        #3;
        checkVal({tag, "_rdy"}, DATA_BITS'({slv_ready, prm_ready, mst_ready, pf_ready}),
                 DATA_BITS'(expRdy));
        e.op   = expOp;
        e.addr = modelAddr;
        e.data = modelData;
        case (expOp)
            3'd3: begin e.addr = slv_addr; e.data = slv_data; end
            3'd2: e.addr = mst_addr;
            3'd1: e.addr = pf_addr;
            default: ;
        endcase
        modelAddr = e.addr;
        modelData = e.data;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset        = 1'b1;
        slv_valid    = 1'b1;
        prm_valid    = 1'b0;
        mst_valid    = 1'b0;
        pf_valid     = 1'b0;
        slv_addr     = 64'h0000_0000_0000_1000;
        slv_data     = {16{32'hDEAD_BEEF}};
        mst_addr     = 64'h0000_0000_0000_2000;
        pf_addr      = 64'h0000_0000_0000_3000;
        q_dataReady  = 1'b0;
        q_almostFull = 1'b0;
        q_errorCode  = 2'd0;
        clear_err    = 1'b0;
        modelAddr    = '0;
        modelData    = '0;

        // Reset: readys low even with slv offering, registers cleared.
        @(posedge clk); #1;
        #3;
        checkVal("rst_rdy", DATA_BITS'({slv_ready, prm_ready, mst_ready, pf_ready}), '0);
        @(posedge clk); #1;
        checkVal("rst_op", DATA_BITS'(q_reqOpcode), '0);
        checkVal("rst_addr", DATA_BITS'(q_reqAddr), '0);
        checkVal("rst_data", q_reqData, '0);
        checkVal("rst_halted", DATA_BITS'(halted), '0);
        checkVal("rst_err", DATA_BITS'(err_latched), '0);
        checkVal("rst_starve", DATA_BITS'(dut.starve_q), '0);
        reset     = 1'b0;
        slv_valid = 1'b0;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 3'd0, "idle");
        checkVal("idle_starve", DATA_BITS'(dut.starve_q), '0);

        // All four offer at once: slv, then prm, then mst, then pf.
        q_dataReady = 1'b1;
        slv_valid = 1'b1; prm_valid = 1'b1; mst_valid = 1'b1; pf_valid = 1'b1;
        applyStimulus(4'b1000, 3'd3, "all_slv");
        slv_valid = 1'b0;
        applyStimulus(4'b0100, 3'd4, "all_prm");
        prm_valid = 1'b0;
        applyStimulus(4'b0010, 3'd2, "all_mst");
        mst_valid = 1'b0;
        applyStimulus(4'b0001, 3'd1, "all_pf");
        pf_valid = 1'b0;
        applyStimulus(4'b0000, 3'd0, "all_idle");

        // Back-to-back promise pops: a pop in flight blocks the next cycle.
        prm_valid = 1'b1;
        applyStimulus(4'b0100, 3'd4, "prm_n");
        applyStimulus(4'b0000, 3'd0, "prm_n1");
        applyStimulus(4'b0100, 3'd4, "prm_n2");
        prm_valid = 1'b0;
        applyStimulus(4'b0000, 3'd0, "prm_idle");

        // Prefetch starvation behind a continuous master stream.
        mst_valid = 1'b1; pf_valid = 1'b1;
        mst_addr  = 64'h0000_0000_0000_2040;
        pf_addr   = 64'h0000_0000_0000_3040;
        for (int i = 0; i < 8; i++) applyStimulus(4'b0010, 3'd2, "stv_mst");
        checkVal("stv_cnt8", DATA_BITS'(dut.starve_q), DATA_BITS'(8));
        applyStimulus(4'b0001, 3'd1, "stv_pf");
        checkVal("stv_cnt0", DATA_BITS'(dut.starve_q), '0);
        applyStimulus(4'b0010, 3'd2, "stv_mst2");
        mst_valid = 1'b0; pf_valid = 1'b0;
        applyStimulus(4'b0000, 3'd0, "stv_idle");

        // Almost-full blocks prefetch without counting starvation.
        q_almostFull = 1'b1; pf_valid = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 3'd0, "af_pf");
        checkVal("af_starve", DATA_BITS'(dut.starve_q), '0);
        mst_valid = 1'b1;
        mst_addr  = 64'h0000_0000_0000_2080;
        applyStimulus(4'b0010, 3'd2, "af_mst");
        mst_valid = 1'b0; pf_valid = 1'b0; q_almostFull = 1'b0;
        applyStimulus(4'b0000, 3'd0, "af_idle");

        // clear_err in RUN does nothing.
        clear_err = 1'b1;
        applyStimulus(4'b0000, 3'd0, "clr_run");
        checkVal("clr_run_halt", DATA_BITS'(halted), '0);
        clear_err = 1'b0;

        // Error with a same-cycle master grant: grant still issues, then HALT.
        q_errorCode = 2'd2; mst_valid = 1'b1;
        mst_addr    = 64'h0000_0000_0000_20C0;
        applyStimulus(4'b0010, 3'd2, "err_mst");
        checkVal("err_halted", DATA_BITS'(halted), DATA_BITS'(1));
        checkVal("err_code", DATA_BITS'(err_latched), DATA_BITS'(2));
        q_errorCode = 2'd0; prm_valid = 1'b1; pf_valid = 1'b1;
        applyStimulus(4'b0000, 3'd0, "halt_block");
        prm_valid = 1'b0; mst_valid = 1'b0; pf_valid = 1'b0;
        slv_valid = 1'b1;
        slv_addr  = 64'h0000_0000_0000_1100;
        slv_data  = {16{32'h1234_5678}};
        applyStimulus(4'b1000, 3'd3, "halt_slv");
        slv_valid = 1'b0; q_errorCode = 2'd1;
        applyStimulus(4'b0000, 3'd0, "halt_err2");
        checkVal("halt_err_hold", DATA_BITS'(err_latched), DATA_BITS'(2));
        q_errorCode = 2'd0; clear_err = 1'b1;
        applyStimulus(4'b0000, 3'd0, "clr");
        checkVal("clr_halted", DATA_BITS'(halted), '0);
        checkVal("clr_err", DATA_BITS'(err_latched), '0);
        clear_err = 1'b0; mst_valid = 1'b1;
        mst_addr  = 64'h0000_0000_0000_2100;
        applyStimulus(4'b0010, 3'd2, "resume_mst");
        mst_valid = 1'b0;

        // Clear and new error together: clear wins, the error re-halts next cycle.
        q_errorCode = 2'd3;
        applyStimulus(4'b0000, 3'd0, "e3");
        checkVal("e3_code", DATA_BITS'(err_latched), DATA_BITS'(3));
        clear_err = 1'b1; q_errorCode = 2'd1;
        applyStimulus(4'b0000, 3'd0, "clr_err_tie");
        checkVal("tie_halted", DATA_BITS'(halted), '0);
        checkVal("tie_err", DATA_BITS'(err_latched), '0);
        clear_err = 1'b0;
        applyStimulus(4'b0000, 3'd0, "rehalt");
        checkVal("rehalt_halted", DATA_BITS'(halted), DATA_BITS'(1));
        checkVal("rehalt_err", DATA_BITS'(err_latched), DATA_BITS'(1));
        q_errorCode = 2'd0; clear_err = 1'b1;
        applyStimulus(4'b0000, 3'd0, "clr2");
        clear_err = 1'b0;
        checkVal("clr2_halted", DATA_BITS'(halted), '0);

        // Reset mid-operation drops the offered op.
        slv_valid = 1'b1; reset = 1'b1;
        slv_addr  = 64'h0000_0000_0000_1200;
        #3;
        checkVal("midrst_rdy", DATA_BITS'({slv_ready, prm_ready, mst_ready, pf_ready}), '0);
        @(posedge clk); #1;
        checkVal("midrst_op", DATA_BITS'(q_reqOpcode), '0);
        checkVal("midrst_addr", DATA_BITS'(q_reqAddr), '0);
        checkVal("midrst_data", q_reqData, '0);
        modelAddr = '0;
        modelData = '0;
        reset = 1'b0; slv_valid = 1'b0;
        applyStimulus(4'b0000, 3'd0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
